// File: rtl/add_sub_flag_stage.sv
// Registered flag-derivation stage for the add/sub datapath: computes
// {V,N,Z,C} from the raw {cout,sum} result, buffers entries in a 2-deep
// in-order FIFO with valid/ready handshake, and counts signed overflows.
module add_sub_flag_stage #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH:0]   in_result,
  input  logic                  in_op1_msb,
  input  logic                  in_op2_msb,
  input  logic                  in_ctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_sum,
  output logic [3:0]            out_flags,
  output logic [CNT_WIDTH-1:0]  ovf_count,
  input  logic                  cnt_clr
);

  logic [DATA_WIDTH-1:0] mem_sum   [2];
  logic [3:0]            mem_flags [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic [DATA_WIDTH-1:0] last_sum;
  logic [3:0]            last_flags;

  logic [DATA_WIDTH-1:0] s;
  logic                  co;
  logic                  f_v, f_n, f_z, f_c;
  logic                  push, pop;

  // Flag derivation from the incoming result and operand sign bits
  always_comb begin
    s   = in_result[DATA_WIDTH-1:0];
    co  = in_result[DATA_WIDTH];
    f_n = s[DATA_WIDTH-1];
    f_z = (s == '0);
    f_c = in_ctrl ? ~co : co;
    if (in_ctrl)
      f_v = (in_op1_msb != in_op2_msb) & (f_n != in_op1_msb);
    else
      f_v = (in_op1_msb == in_op2_msb) & (f_n != in_op1_msb);
  end

  // Handshake decode; in_ready depends only on registered occupancy
  always_comb begin
    in_ready  = (count < 2'd2) & ~rst;
    out_valid = (count != 2'd0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    // When empty, present the last popped entry rather than a stale slot
    out_sum   = out_valid ? mem_sum[rd_ptr]   : last_sum;
    out_flags = out_valid ? mem_flags[rd_ptr] : last_flags;
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      last_sum   <= '0;
      last_flags <= '0;
    end else begin
      if (push) begin
        mem_sum[wr_ptr]   <= s;
        mem_flags[wr_ptr] <= {f_v, f_n, f_z, f_c};
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        last_sum   <= mem_sum[rd_ptr];
        last_flags <= mem_flags[rd_ptr];
        rd_ptr     <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Saturating overflow-event counter; clear wins over increment
  always_ff @(posedge clk) begin
    if (rst || cnt_clr)
      ovf_count <= '0;
    else if (push && f_v && (ovf_count != '1))
      ovf_count <= ovf_count + 1'b1;
  end

endmodule
